decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-instruction control decode: a buffered decode stage between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and decodes register indices, immediate, instruction class and illegal flag at enqueue.
- Holds up to DEPTH decoded entries and presents the head entry to execute over a second valid/ready handshake.
- Supports a synchronous flush for branch/jump redirect and a sticky halt-stall.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- HALT_INST, 32'h00000073: instruction encoding that triggers the halt-stall.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all entries and clear halt-stall.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  queue accepts this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  32  PC of in_inst.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  execute consumes the head entry.
- out_inst  output  32  head instruction.
- out_pc  output  32  head PC.
- out_rs1, out_rs2, out_rd  output  5 each  decoded register indices.
- out_imm  output  32  sign-extended immediate.
- out_class  output  3  0 OP, 1 OP-IMM/LUI/AUIPC, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 SYSTEM/MISC-MEM.
- out_illegal  output  1  opcode not recognised.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- halt_pending  output  1  HALT_INST has been accepted; input is stalled.

Behaviour:
- Reset (nRST=0, asynchronous): pointers=0, count=0, halt_pending=0, storage contents don't-care. While reset is asserted: out_valid=0, in_ready=0, all out_* fields=0.
- Decode is combinational on in_inst and is registered with the entry when the push occurs.
- Immediate formats:
  - I-type: OP-IMM, LOAD, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - OP: imm=0.
  - Sign bit is always inst[31].
- Unknown opcode: class=7, illegal=1, imm=0.
- rs1/rs2/rd are taken raw from bit fields regardless of format.
- in_ready = (count < DEPTH) && !halt_pending && !flush.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- out_valid = (count != 0). out_* reflect the head entry; all are 0 when empty (unless the optional feature is enabled).
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full queue is impossible because in_ready=0; no pass-through on full.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Halt: a push with in_inst == HALT_INST sets halt_pending on the next edge. halt_pending holds until flush or reset. Entries already queued, including the halt entry itself, still drain normally.
- Flush takes priority over push and pop in the same cycle:
  - next edge sets count=0, pointers=0, halt_pending=0;
  - the out_ready handshake in the flush cycle is ignored, i.e. no pop is counted.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, i.e. 1 cycle.

Optional Feature:
- Macro DECODE_QUEUE_BYPASS_EN.
- When defined: if count==0, in_valid=1, !halt_pending and !flush, then:
  - out_valid is asserted combinationally;
  - out_* show the live decode of in_inst/in_pc;
  - if out_ready=1 in that cycle, the instruction is consumed without being written (count stays 0);
  - if out_ready=0, it is pushed normally.
- When not defined: 1-cycle latency always, and out_valid depends only on count.

Test Plan:
- Reset then push addi x1,x2,-5 (32'hFFB10093), out_ready=0 -> after 1 edge: out_valid=1, out_class=1, out_rs1=2, out_rd=1, out_imm=32'hFFFFFFFB, count=1.
- Push 4 instructions with out_ready=0 (DEPTH=4) -> count=4, in_ready=0. Fifth in_valid is held and not lost. Pop one -> in_ready=1 next cycle.
- Full queue with simultaneous push and pop for 8 cycles -> count stays 4, in-order PCs out, wrap-around correct.
- Push sw x5,-4(x2) (32'hFE512E23) then beq x1,x2,-8 (32'hFE208CE3) -> class 3 with imm=32'hFFFFFFFC, then class 4 with imm=32'hFFFFFFF8.
- Push 32'h00000073 -> halt_pending=1, in_ready=0. Drain -> halt entry reaches out with class 7. flush -> halt_pending=0, count=0, in_ready=1.
- Flush asserted with count=3 and push and pop pending -> next cycle count=0, out_valid=0, no entry consumed or added. Asynchronous nRST pulse mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and execute-side valid/ready bundle for decode_queue.
// The slave modport is the queue's view; the master modport is the fetch/execute view.
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_class;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: buffered decode stage between fetch and execute.
// Instructions are decoded at enqueue and stored with their decode results in a
// DEPTH-entry circular buffer; the head entry is offered to execute.
// Optional macro DECODE_QUEUE_BYPASS_EN: when the queue is empty the live decode
// of the incoming instruction is presented directly and may be consumed in the
// same cycle without being written.
module decode_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] HALT_INST = 32'h00000073
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    decode_queue_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halt_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic        illegal;
    } entry_t;

    // Register fields are taken raw; the immediate format follows the opcode.
    function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
        entry_t e;
        e.inst    = inst;
        e.pc      = pc;
        e.rs1     = inst[19:15];
        e.rs2     = inst[24:20];
        e.rd      = inst[11:7];
        e.imm     = '0;
        e.cls     = 3'd7;
        e.illegal = 1'b0;
        case (inst[6:0])
            7'b0110011: e.cls = 3'd0;
            7'b0010011: begin e.cls = 3'd1; e.imm = {{20{inst[31]}}, inst[31:20]}; end
            7'b0110111,
            7'b0010111: begin e.cls = 3'd1; e.imm = {inst[31:12], 12'b0}; end
            7'b0000011: begin e.cls = 3'd2; e.imm = {{20{inst[31]}}, inst[31:20]}; end
            7'b0100011: begin
                e.cls = 3'd3;
                e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                e.cls = 3'd4;
                e.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b1101111: begin
                e.cls = 3'd5;
                e.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin e.cls = 3'd6; e.imm = {{20{inst[31]}}, inst[31:20]}; end
            7'b1110011,
            7'b0001111: begin e.cls = 3'd7; e.imm = {{20{inst[31]}}, inst[31:20]}; end
            default:    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          wr_en;
    logic          pop;
    logic          bypass;

    assign in_entry    = decode(bus.in_inst, bus.in_pc);
    assign bus.in_ready = nRST && (count < FULL) && !halt_pending && !flush;
    assign accept      = bus.in_valid && bus.in_ready;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = nRST && (count == '0) && bus.in_valid && !halt_pending && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction taken by execute in the same cycle is never stored.
    assign wr_en         = accept && !(bypass && bus.out_ready);
    assign pop           = (count != '0) && bus.out_ready && !flush;
    assign bus.out_valid = nRST && ((count != '0) || bypass);

    // Select head entry, live bypass decode, or zeros when nothing is valid.
    always_comb begin
        head = '0;
        if (nRST) begin
            if (count != '0)
                head = mem[rd_ptr];
            else if (bypass)
                head = in_entry;
        end
    end

    assign bus.out_inst    = head.inst;
    assign bus.out_pc      = head.pc;
    assign bus.out_imm     = head.imm;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_rd      = head.rd;
    assign bus.out_class   = head.cls;
    assign bus.out_illegal = head.illegal;

    // Entry storage carries data only, so it is not reset.
    always_ff @(posedge CLK) begin
        if (wr_en && !flush)
            mem[wr_ptr] <= in_entry;
    end

    // Pointers, occupancy and halt-stall; flush outranks push and pop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && (bus.in_inst == HALT_INST))
                halt_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue (DEPTH=4, default build).
module tb_decode_queue;
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic       halt_pending;

    decode_queue_if bus();

    decode_queue #(.DEPTH(4), .HALT_INST(32'h00000073)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .bus(bus),
        .count(count), .halt_pending(halt_pending)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    bit          halt_m;
    int          vectors;
    int          miscompares;
    logic [31:0] prog [10];

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic s;
        s = i[31];
        e.inst = i; e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.imm = 32'h0; e.cls = 3'd7; e.ill = 1'b0;
        if (i[6:0] == 7'h33) e.cls = 3'd0;
        else if (i[6:0] == 7'h13) begin e.cls = 3'd1; e.imm = {{20{s}}, i[31:20]}; end
        else if (i[6:0] == 7'h37 || i[6:0] == 7'h17) begin e.cls = 3'd1; e.imm = {i[31:12], 12'h000}; end
        else if (i[6:0] == 7'h03) begin e.cls = 3'd2; e.imm = {{20{s}}, i[31:20]}; end
        else if (i[6:0] == 7'h23) begin e.cls = 3'd3; e.imm = {{20{s}}, i[31:25], i[11:7]}; end
        else if (i[6:0] == 7'h63) begin e.cls = 3'd4; e.imm = {{20{s}}, i[7], i[30:25], i[11:8], 1'b0}; end
        else if (i[6:0] == 7'h6F) begin e.cls = 3'd5; e.imm = {{12{s}}, i[19:12], i[20], i[30:21], 1'b0}; end
        else if (i[6:0] == 7'h67) begin e.cls = 3'd6; e.imm = {{20{s}}, i[31:20]}; end
        else if (i[6:0] == 7'h73 || i[6:0] == 7'h0F) e.imm = {{20{s}}, i[31:20]};
        else e.ill = 1'b1;
        return e;
    endfunction

    // One clock cycle: check control against the model, score any pop, record any push.
    task automatic tick();
        exp_t h;
        bit   exp_rdy;
        bit   do_push;
        bit   do_pop;
        #1;
        exp_rdy = (sb.size() < 4) && !halt_m && !flush;
        vectors++;
        if (bus.in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b", bus.in_ready, exp_rdy);
        end
        vectors++;
        if (count !== 3'(sb.size())) begin
            miscompares++;
            $display("FAIL count: got %0d expected %0d", count, sb.size());
        end
        vectors++;
        if (bus.out_valid !== (sb.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, sb.size() != 0);
        end
        vectors++;
        if (halt_pending !== halt_m) begin
            miscompares++;
            $display("FAIL halt_pending: got %b expected %b", halt_pending, halt_m);
        end
        if (sb.size() == 0) begin
            vectors++;
            if ({bus.out_inst, bus.out_pc, bus.out_imm} !== 96'h0) begin
                miscompares++;
                $display("FAIL empty_out: got inst %h pc %h imm %h expected zeros",
                         bus.out_inst, bus.out_pc, bus.out_imm);
            end
        end
        do_push = bus.in_valid && exp_rdy;
        do_pop  = (sb.size() != 0) && bus.out_ready && !flush;
        if (do_pop) begin
            h = sb[0];
            vectors++;
            if ({bus.out_inst, bus.out_pc} !== {h.inst, h.pc}) begin
                miscompares++;
                $display("FAIL head_id: got inst %h pc %h expected inst %h pc %h",
                         bus.out_inst, bus.out_pc, h.inst, h.pc);
            end
            vectors++;
            if (bus.out_imm !== h.imm) begin
                miscompares++;
                $display("FAIL head_imm: got %h expected %h (pc %h)", bus.out_imm, h.imm, h.pc);
            end
            vectors++;
            if ({bus.out_class, bus.out_illegal, bus.out_rs1, bus.out_rs2, bus.out_rd} !==
                {h.cls, h.ill, h.rs1, h.rs2, h.rd}) begin
                miscompares++;
                $display("FAIL head_fields: got class %0d ill %b rs1 %0d rs2 %0d rd %0d expected class %0d ill %b rs1 %0d rs2 %0d rd %0d",
                         bus.out_class, bus.out_illegal, bus.out_rs1, bus.out_rs2, bus.out_rd,
                         h.cls, h.ill, h.rs1, h.rs2, h.rd);
            end
        end
        if (flush) begin
            sb.delete();
            halt_m = 1'b0;
        end else begin
            if (do_pop)
                void'(sb.pop_front());
            if (do_push) begin
                sb.push_back(model(bus.in_inst, bus.in_pc));
                if (bus.in_inst == 32'h00000073)
                    halt_m = 1'b1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++)
            tick();
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL drain: count %0d expected 0 within budget", count);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'hFFB10093;
        bus.in_pc    = 32'h0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.in_ready, count, halt_pending} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got valid %b ready %b count %0d halt %b expected all 0",
                     bus.out_valid, bus.in_ready, count, halt_pending);
        end
        vectors++;
        if ({bus.out_inst, bus.out_pc, bus.out_class} !== 67'h0) begin
            miscompares++;
            $display("FAIL reset_out: got inst %h pc %h class %0d expected 0",
                     bus.out_inst, bus.out_pc, bus.out_class);
        end
        @(negedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        push_one(32'hFFB10093, 32'h100);
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_class, bus.out_rs1, bus.out_rd, count} !==
            {1'b1, 3'd1, 5'd2, 5'd1, 3'd1}) begin
            miscompares++;
            $display("FAIL addi_fields: got valid %b class %0d rs1 %0d rd %0d count %0d expected 1 1 2 1 1",
                     bus.out_valid, bus.out_class, bus.out_rs1, bus.out_rd, count);
        end
        vectors++;
        if (bus.out_imm !== 32'hFFFFFFFB) begin
            miscompares++;
            $display("FAIL addi_imm: got %h expected fffffffb", bus.out_imm);
        end
        drain();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++)
            push_one(prog[k], 32'h200 + 32'(4 * k));
        #1;
        vectors++;
        if ({count, bus.in_ready} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL full: got count %0d ready %b expected 4 0", count, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_inst  = prog[4];
        bus.in_pc    = 32'h210;
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if ({count, bus.in_ready} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL after_pop: got count %0d ready %b expected 3 1", count, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++)
            push_one(prog[k + 5], 32'h300 + 32'(4 * k));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = prog[k % 10];
            bus.in_pc    = 32'h400 + 32'(4 * k);
            tick();
        end
        drain();
    endtask

    task automatic test_decode();
        push_one(32'hFE512E23, 32'h500);
        push_one(32'hFE208CE3, 32'h504);
        #1;
        vectors++;
        if ({bus.out_class, bus.out_imm, bus.out_rs1, bus.out_rs2} !== {3'd3, 32'hFFFFFFFC, 5'd2, 5'd5}) begin
            miscompares++;
            $display("FAIL sw: got class %0d imm %h rs1 %0d rs2 %0d expected 3 fffffffc 2 5",
                     bus.out_class, bus.out_imm, bus.out_rs1, bus.out_rs2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if ({bus.out_class, bus.out_imm} !== {3'd4, 32'hFFFFFFF8}) begin
            miscompares++;
            $display("FAIL beq: got class %0d imm %h expected 4 fffffff8", bus.out_class, bus.out_imm);
        end
        drain();
    endtask

    task automatic test_halt();
        push_one(32'h00208033, 32'h600);
        push_one(32'h00000073, 32'h604);
        #1;
        vectors++;
        if ({halt_pending, bus.in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL halt_set: got halt %b ready %b expected 1 0", halt_pending, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00412083;
        bus.in_pc    = 32'h608;
        tick();
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_class, bus.out_inst} !== {1'b1, 3'd7, 32'h00000073}) begin
            miscompares++;
            $display("FAIL halt_head: got valid %b class %0d inst %h expected 1 7 00000073",
                     bus.out_valid, bus.out_class, bus.out_inst);
        end
        tick();
        bus.out_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vectors++;
        if ({halt_pending, count, bus.in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_flush: got halt %b count %0d ready %b expected 0 0 1",
                     halt_pending, count, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            push_one(prog[k + 2], 32'h700 + 32'(4 * k));
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h00208033;
        bus.in_pc     = 32'h7F0;
        bus.out_ready = 1'b1;
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if ({count, bus.out_valid} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL flush: got count %0d valid %b expected 0 0", count, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h123450B7;
        bus.in_pc    = 32'h800;
        tick();
        bus.in_pc    = 32'h804;
        tick();
        #3;
        nRST = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.in_ready, count, halt_pending} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_ctrl: got valid %b ready %b count %0d halt %b expected all 0",
                     bus.out_valid, bus.in_ready, count, halt_pending);
        end
        vectors++;
        if ({bus.out_inst, bus.out_pc, bus.out_imm, bus.out_rd} !== 101'h0) begin
            miscompares++;
            $display("FAIL async_out: got inst %h pc %h imm %h rd %0d expected 0",
                     bus.out_inst, bus.out_pc, bus.out_imm, bus.out_rd);
        end
        sb.delete();
        halt_m = 1'b0;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        nRST = 1'b1;
        tick();
        push_one(32'hFFB10093, 32'h900);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        halt_m        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        prog[0] = 32'hFFB10093;
        prog[1] = 32'hFE512E23;
        prog[2] = 32'hFE208CE3;
        prog[3] = 32'h00208033;
        prog[4] = 32'h123450B7;
        prog[5] = 32'h0040006F;
        prog[6] = 32'h00008067;
        prog[7] = 32'h00412083;
        prog[8] = 32'hFFFFFFFF;
        prog[9] = 32'h80000017;
        test_reset();
        test_addi();
        test_full();
        test_back_to_back();
        test_decode();
        test_halt();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
